fetch_unit: RTL and testbench
=============================

# fetch_unit

Decoupled instruction-fetch front end for the 5-stage pipeline. Owns the fetch PC, issues in-order word requests to a variable-latency instruction memory, and buffers returned words with their PCs in a small prefetch queue. The decode flop consumes the queue through a valid/ready handshake. A branch or jump redirect from decode discards all stale work, both queued and in flight.

## Interface
Parameters:
- DEPTH, 4: prefetch queue entries and maximum outstanding requests; power of 2, ≥2
- RESET_PC, 32'h0000_0000: first fetch address after reset

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_resp_valid  in  1  response word returned; responses arrive in request order, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect  in  1  taken branch/jump from decode; overrides everything this cycle
- redirect_pc  in  32  new fetch PC; bits [1:0] forced to 0
- instr_valid  out  1  queue head holds a valid instruction
- instr_ready  in  1  decode accepts head (deasserted on decode stall)
- instr  out  32  head instruction; 32'h0 (NOP) when instr_valid=0
- instr_pc  out  32  PC of head; 32'h0 when instr_valid=0

## Operation
- State: fpc (next request address), rpc (PC of next kept response), inflight (accepted requests not yet responded), drop (in-flight responses to discard), queue with count. All counters are $clog2(DEPTH)+1 bits wide.
- Request: imem_req_valid = !redirect && (inflight + count < DEPTH). imem_req_addr = fpc. On valid&ready: fpc += 4 (wraps mod 2^32), inflight += 1.
- Response: inflight -= 1 on every imem_resp_valid.
  - If drop≠0 or redirect: the word is discarded and drop decrements (saturates at 0).
  - Otherwise {rpc, data} is pushed, then rpc += 4.
- Credit: the rule inflight+count<DEPTH guarantees a push never finds the queue full. Overflow is an assertion failure.
- Pop: on instr_valid&instr_ready the head advances and count decrements. Push and pop in the same cycle leave count unchanged.
- Redirect, single cycle:
  - fpc and rpc load redirect_pc.
  - Queue clears (count=0); any pop that cycle is ignored.
  - drop ← inflight − imem_resp_valid, counting all surviving in-flight requests. No request is issued that cycle.
  - Next cycle, fetch resumes at redirect_pc.
- Back-to-back redirects: the latest one wins. drop is recomputed from inflight each time.
- No explicit FSM. Behaviour is fully determined by the counters above.

## Timing
- Reset values: imem_req_valid=0 while rst is high; instr_valid=0, instr=0, instr_pc=0; fpc=rpc=RESET_PC; inflight=drop=count=0.
- Reset deasserted mid-transaction: all in-flight responses are lost by definition. The memory must also be reset.
- First request: imem_req_valid=1 in the first cycle after rst falls, addr=RESET_PC.
- Latency: request accepted in cycle t, response in cycle t+L, instr_valid in cycle t+L+1. There is no bypass path from response to instr.
- Throughput: one instruction per cycle sustained when L+1 ≤ DEPTH and decode never stalls.
- Redirect asserted in cycle t: instr_valid=0 in t+1. The request for redirect_pc issues in t+1. The earliest valid instruction from the new stream appears in t+L+2.
- All outputs except imem_req_valid are registered. imem_req_valid is combinational from redirect and the counters.

## Structure
- Shared package, fetch_pkg: PC_INC=32'd4, NOP_INSTR=32'h0, RESET_PC default, and the fetch entry typedef {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch entries with DEPTH parameter, push/pop/clear inputs, count/head outputs, and an overflow assertion. clear has priority over push and pop.

## Test plan
- Reset then free-run, memory L=1, always ready: requests 0x0, 0x4, 0x8…; instr_pc sequence 0x0, 0x4… with instr_valid from cycle 3 onward, one per cycle.
- Decode stalls (instr_ready=0) for 10 cycles, L=2, DEPTH=4: inflight+count reaches 4, then imem_req_valid=0. No word is lost or duplicated after the stall releases.
- Redirect to 0x100 while 3 requests are in flight with L=3: those 3 responses are discarded. The next instr_valid shows instr_pc=0x100, in cycle t+5.
- Redirect in the same cycle a response arrives and decode pops: the response and the pop are both ignored. The queue is empty next cycle and drop = inflight−1.
- Two redirects on consecutive cycles (0x200, then 0x300): the first instruction delivered is 0x300. 0x200 never appears.
- rst pulsed while the queue is full: all outputs return to reset values within the same cycle, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and the fetch entry type used by the fetch front end.
package fetch_pkg;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of fetch entries, clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = PW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t push_entry,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Request credit upstream should make a push into a full queue impossible.
    overflow_a : assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch front end: issues in-order word fetches, queues returned words with
// their PCs, and flushes queued and in-flight work on a redirect from decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [31:0]   redirect_pc_aligned;
    logic          req_fire;
    logic          keep_resp;
    logic          fifo_pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;

    // Dropped-but-pending responses still hold credit so a push never finds the queue full.
    assign occupancy           = {1'b0, inflight_q} + {1'b0, count};
    assign imem_req_valid      = !rst && !redirect && (occupancy < DEPTH_C);
    assign imem_req_addr       = fpc_q;
    assign req_fire            = imem_req_valid && imem_req_ready;
    assign keep_resp           = imem_resp_valid && !redirect && (drop_q == '0);
    assign fifo_pop            = instr_valid && instr_ready && !redirect;
    assign redirect_pc_aligned = {redirect_pc[31:2], 2'b00};
    assign push_entry          = '{pc: rpc_q, instr: imem_resp_data};

    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        if (req_fire) begin
            fpc_d      = fpc_q + PC_INC;
            inflight_d = inflight_d + CW'(1);
        end
        if (imem_resp_valid) begin
            inflight_d = inflight_d - CW'(1);
        end
        if (keep_resp) begin
            rpc_d = rpc_q + PC_INC;
        end else if (imem_resp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (redirect) begin
            fpc_d  = redirect_pc_aligned;
            rpc_d  = redirect_pc_aligned;
            drop_d = inflight_q - CW'(imem_resp_valid);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q      <= RESET_PC;
            rpc_q      <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fpc_q      <= fpc_d;
            rpc_q      <= rpc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (keep_resp),
        .pop        (fifo_pop),
        .clear      (redirect),
        .push_entry (push_entry),
        .count      (count),
        .head       (head)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a request-level memory and queue model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each accepted request: its address, the cycle its response is due, and whether a
    // redirect has since made it stale.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_fpc;
    int          cyc;
    int          lat;
    int          errors;
    int          checks;
    logic        last_valid;
    logic [31:0] last_pc;
    logic        last_req_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        redirect        = 1'b0;
        redirect_pc     = '0;
        instr_ready     = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_pc", instr_pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        m_fpc = RST_PC;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("first_req_valid", imem_req_valid, 1);
        check("first_req_addr", imem_req_addr, RST_PC);
    endtask

    // One cycle: check registered outputs, drive inputs, check the request, advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input logic mrdy);
        logic  resp;
        logic  exp_rv;
        mreq_t m;
        @(negedge clk);
        cyc++;
        last_valid = instr_valid;
        last_pc    = instr_pc;
        if (exp_q.size() != 0) begin
            check("instr_valid", instr_valid, 1);
            check("instr_pc", instr_pc, exp_q[0][63:32]);
            check("instr", instr, exp_q[0][31:0]);
        end else begin
            check("instr_valid_idle", instr_valid, 0);
            check("instr_pc_idle", instr_pc, 32'h0);
            check("instr_idle", instr, NOP_INSTR);
        end
        resp            = (mem_q.size() != 0) && (mem_q[0].due == cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mem_q[0].addr) : $urandom;
        redirect        = redir;
        redirect_pc     = rpc;
        instr_ready     = rdy;
        imem_req_ready  = mrdy;
        #1;
        last_req_valid = imem_req_valid;
        exp_rv = !redir && ((mem_q.size() + exp_q.size()) < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, m_fpc);
        if (exp_q.size() != 0 && rdy && !redir) void'(exp_q.pop_front());
        if (resp) begin
            m = mem_q.pop_front();
            if (!m.stale && !redir) exp_q.push_back({m.addr, mem_word(m.addr)});
        end
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            m_fpc = {rpc[31:2], 2'b00};
        end else if (imem_req_valid && mrdy) begin
            mem_q.push_back('{addr: m_fpc, due: cyc + lat, stale: 1'b0});
            m_fpc = m_fpc + 32'd4;
        end
    endtask

    // Free-runs until the first valid instruction after a redirect and checks its PC and cycle.
    task automatic track(input string tag, input logic [31:0] target, input int exp_delay, input int budget);
        int  t0;
        bit  found;
        t0    = cyc;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (!found && last_valid) begin
                found = 1'b1;
                check({tag, "_pc"}, last_pc, target);
                check({tag, "_delay"}, cyc - t0, exp_delay);
            end
        end
        if (!found) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        int c0;
        int first;
        errors = 0;
        checks = 0;
        cyc    = 0;
        lat    = 1;
        rst    = 1'b1;

        // Free run, L=1: one instruction per cycle, first valid two cycles after acceptance.
        do_reset();
        lat   = 1;
        c0    = cyc + 1;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            if (first < 0 && last_valid) first = cyc;
        end
        check("first_valid_delay", first - c0, 2);

        // Decode stall, L=2: fetch throttles, nothing lost after release.
        do_reset();
        lat = 2;
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("stall_throttle", last_req_valid, 0);
        repeat (15) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with requests in flight, L=3.
        do_reset();
        lat = 3;
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        track("redir_100", 32'h0000_0100, lat + 2, 10);

        // Redirect in the cycle a response arrives and decode pops, L=1.
        do_reset();
        lat = 1;
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0043, 1'b1, 1'b1);
        track("redir_resp_pop", 32'h0000_0040, lat + 2, 8);

        // Back-to-back redirects: the second wins.
        lat = 1;
        step(1'b1, 32'h0000_0200, 1'b1, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        track("redir_b2b", 32'h0000_0300, lat + 2, 8);

        // Reset while the queue is full.
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1);
        check("full_before_reset", last_valid, 1);
        do_reset();
        repeat (8) step(1'b0, 32'h0, 1'b1, 1'b1);

        // Random traffic per latency.
        for (int l = 1; l <= 3; l++) begin
            do_reset();
            lat = l;
            repeat (300) begin
                step($urandom_range(0, 19) == 0, $urandom,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
